// File: rtl/pipelined_config_multiplier_pkg.sv
// Shared types and derived constants for the pipelined configurable multiplier.
package pipelined_config_multiplier_pkg;

    // The payload struct is sized by this configuration. The top module
    // refuses at elaboration any parameter set that does not match it.
    localparam int CFG_DATA_WIDTH     = 16;
    localparam int CFG_PIPELINE_DEPTH = 4;
    localparam int CFG_TAG_WIDTH      = 4;

    localparam int PRODUCT_PER_STAGE = CFG_DATA_WIDTH / CFG_PIPELINE_DEPTH;
    localparam int RESULT_WIDTH      = 2 * CFG_DATA_WIDTH;

    // One in-flight operation. mag_a and mag_b are operand magnitudes.
    // sum is the running magnitude sum: each adder result is kept at full
    // width, so any carry is absorbed into sum. The low bits of sum that
    // are already complete stay in place, which keeps them aligned with
    // the upper bits all the way to the output.
    typedef struct packed {
        logic                      valid;
        logic                      sign;
        logic [CFG_TAG_WIDTH-1:0]  tag;
        logic [CFG_DATA_WIDTH-1:0] mag_a;
        logic [CFG_DATA_WIDTH-1:0] mag_b;
        logic [RESULT_WIDTH-1:0]   sum;
    } stage_t;

    // Absolute value of an operand. -2^(W-1) maps to the unsigned value 2^(W-1).
    function automatic logic [CFG_DATA_WIDTH-1:0] magnitude(
        input logic [CFG_DATA_WIDTH-1:0] value,
        input logic                      negative
    );
        return negative ? -value : value;
    endfunction

endpackage

// File: rtl/pipelined_config_multiplier_stage.sv
// Combinational accumulation of PRODUCT_PER_STAGE partial-product rows.
module config_multiplier_stage
    import pipelined_config_multiplier_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam int ROW_BASE = STAGE * PRODUCT_PER_STAGE;

    logic [RESULT_WIDTH-1:0] acc;

    // Add each selected row of |A|, shifted to its row position, into the running sum.
    always_comb begin
        acc = stage_i.sum;
        for (int r = 0; r < PRODUCT_PER_STAGE; r++) begin
            if (stage_i.mag_b[ROW_BASE + r]) begin
                acc = acc + ({{CFG_DATA_WIDTH{1'b0}}, stage_i.mag_a} << (ROW_BASE + r));
            end
        end
        stage_o     = stage_i;
        stage_o.sum = acc;
    end

endmodule

// File: rtl/pipelined_config_multiplier.sv
// Pipelined signed/unsigned multiplier with a tag sideband, valid/ready
// handshake, flush and a global clock enable.
module pipelined_config_multiplier
    import pipelined_config_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH     = CFG_DATA_WIDTH,
    parameter int PIPELINE_DEPTH = CFG_PIPELINE_DEPTH,
    parameter int TAG_WIDTH      = CFG_TAG_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_WIDTH-1:0]   operand_A_i,
    input  logic [DATA_WIDTH-1:0]   operand_B_i,
    input  logic                    signed_A_i,
    input  logic                    signed_B_i,
    input  logic [TAG_WIDTH-1:0]    tag_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [2*DATA_WIDTH-1:0] result_o,
    output logic [TAG_WIDTH-1:0]    tag_o
);

    if (DATA_WIDTH < 4 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "DATA_WIDTH must be a power of 2 and at least 4");
    end
    if (PIPELINE_DEPTH < 2 || (DATA_WIDTH % PIPELINE_DEPTH) != 0) begin : g_bad_depth
        $fatal(1, "PIPELINE_DEPTH must be at least 2 and divide DATA_WIDTH");
    end
    if (DATA_WIDTH != CFG_DATA_WIDTH || PIPELINE_DEPTH != CFG_PIPELINE_DEPTH
        || TAG_WIDTH != CFG_TAG_WIDTH) begin : g_bad_cfg
        $fatal(1, "parameters must match the package configuration");
    end

    stage_t                  stage_q [PIPELINE_DEPTH];
    stage_t                  stage_d [PIPELINE_DEPTH];
    stage_t                  stage_nx[PIPELINE_DEPTH];
    stage_t                  stage_in;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic                    valid_o_q, valid_o_d;
    logic                    advance;
    logic                    neg_a, neg_b;

    assign advance  = clk_en_i & (~valid_o_q | ready_i);
    assign ready_o  = advance & ~rst_i;
    assign valid_o  = valid_o_q;
    assign result_o = result_q;
    assign tag_o    = tag_q;

    // Stage 0 input: operand magnitudes, result sign and tag, with an empty sum.
    always_comb begin
        neg_a          = signed_A_i & operand_A_i[DATA_WIDTH-1];
        neg_b          = signed_B_i & operand_B_i[DATA_WIDTH-1];
        stage_in       = '0;
        stage_in.valid = valid_i;
        stage_in.sign  = neg_a ^ neg_b;
        stage_in.tag   = tag_i;
        stage_in.mag_a = magnitude(operand_A_i, neg_a);
        stage_in.mag_b = magnitude(operand_B_i, neg_b);
    end

    for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            config_multiplier_stage #(.STAGE(k)) u_stage (
                .stage_i (stage_in),
                .stage_o (stage_nx[k])
            );
        end else begin : g_next
            config_multiplier_stage #(.STAGE(k)) u_stage (
                .stage_i (stage_q[k-1]),
                .stage_o (stage_nx[k])
            );
        end
    end

    // Next state: shift on advance, apply sign at the output, flush clears valids.
    always_comb begin
        stage_d   = stage_q;
        result_d  = result_q;
        tag_d     = tag_q;
        valid_o_d = valid_o_q;
        if (advance) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                stage_d[k] = stage_nx[k];
            end
            valid_o_d = stage_q[PIPELINE_DEPTH-1].valid;
            tag_d     = stage_q[PIPELINE_DEPTH-1].tag;
            result_d  = stage_q[PIPELINE_DEPTH-1].sign ? -stage_q[PIPELINE_DEPTH-1].sum
                                                        : stage_q[PIPELINE_DEPTH-1].sum;
        end
        if (clk_en_i && flush_i) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                stage_d[k].valid = 1'b0;
            end
            valid_o_d = 1'b0;
        end
    end

    // Pipeline and output registers; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            result_q  <= '0;
            tag_q     <= '0;
            valid_o_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
            valid_o_q <= valid_o_d;
        end
    end

endmodule

// File: tb/tb_pipelined_config_multiplier.sv
// Scoreboard bench for pipelined_config_multiplier (DATA_WIDTH=16, PIPELINE_DEPTH=4).
module tb_pipelined_config_multiplier;

    logic        clk_i, rst_i, clk_en_i, flush_i, valid_i, ready_o;
    logic [15:0] operand_A_i, operand_B_i;
    logic        signed_A_i, signed_B_i;
    logic [3:0]  tag_i;
    logic        valid_o, ready_i;
    logic [31:0] result_o;
    logic [3:0]  tag_o;

    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    int          checks = 0;
    int          passed = 0;

    pipelined_config_multiplier #(.DATA_WIDTH(16), .PIPELINE_DEPTH(4), .TAG_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .operand_A_i(operand_A_i),
        .operand_B_i(operand_B_i), .signed_A_i(signed_A_i), .signed_B_i(signed_B_i),
        .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .tag_o(tag_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [35:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sb, input logic [3:0] t);
        longint av, bv, p;
        logic [31:0] lo;
        av = sa ? longint'($signed(a)) : longint'(a);
        bv = sb ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        lo = p[31:0];
        return {lo, t};
    endfunction

    // Inputs change at posedge+1, so the negedge sees what the next posedge will sample.
    always @(negedge clk_i) begin
        if (!rst_i && valid_i && ready_o && !flush_i)
            exp_q.push_back(model(operand_A_i, operand_B_i, signed_A_i, signed_B_i, tag_i));
        if (!rst_i && valid_o && ready_i && clk_en_i)
            got_q.push_back({result_o, tag_o});
    end

    task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sa, input logic sb, input logic [3:0] t);
        operand_A_i = a; operand_B_i = b; signed_A_i = sa; signed_B_i = sb; tag_i = t;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", valid_o); else passed++;
        checks++; if (result_o !== 32'h0) $display("FAIL reset_result got=%0h exp=0", result_o); else passed++;
        checks++; if (tag_o !== 4'h0) $display("FAIL reset_tag got=%0h exp=0", tag_o); else passed++;
        checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready got=%0h exp=0", ready_o); else passed++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) $display("FAIL ready_after_reset got=%0h exp=1", ready_o); else passed++;
    endtask

    task automatic test_unsigned;
        int lat;
        set_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 4'd3);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
        checks++; if (lat !== 4) $display("FAIL unsigned_latency got=%0d exp=4", lat); else passed++;
        checks++; if (result_o !== 32'hFFFE0001) $display("FAIL unsigned_result got=%0h exp=fffe0001", result_o); else passed++;
        checks++; if (tag_o !== 4'd3) $display("FAIL unsigned_tag got=%0h exp=3", tag_o); else passed++;
        repeat (2) begin @(posedge clk_i); #1; end
        checks++; if (got_q.size() !== exp_q.size() || got_q.size() !== 1)
            $display("FAIL unsigned_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [35:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) $display("FAIL unsigned_sb got=%0h exp=%0h", g, e); else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_signed;
        logic [15:0] va[6], vb[6];
        logic        vsa[6], vsb[6];
        int          idx;
        va  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFF0};
        vb  = '{16'h8000, 16'h0002, 16'hFFFF, 16'h8000, 16'hABCD, 16'hFFF0};
        vsa = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vsb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            set_op(va[i], vb[i], vsa[i], vsb[i], 4'(i + 8));
            valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        repeat (8) begin @(posedge clk_i); #1; end
        checks++; if (got_q.size() !== 6) $display("FAIL signed_count got=%0d exp=6", got_q.size()); else passed++;
        idx = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [35:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) $display("FAIL signed_sb got=%0h exp=%0h", g, e); else passed++;
            if (idx == 0) begin
                checks++; if (g[35:4] !== 32'h40000000) $display("FAIL signed_min_min got=%0h exp=40000000", g[35:4]); else passed++;
            end
            if (idx == 1) begin
                checks++; if (g[35:4] !== 32'hFFFFFFFE) $display("FAIL signed_mixed got=%0h exp=fffffffe", g[35:4]); else passed++;
            end
            idx++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_streaming;
        logic [31:0] hold_r;
        logic [3:0]  hold_t;
        for (int i = 0; i < 8; i++) begin
            set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'(i));
            valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        hold_r = result_o; hold_t = tag_o;
        checks++; if (valid_o !== 1'b1) $display("FAIL stall_valid got=%0h exp=1", valid_o); else passed++;
        for (int c = 0; c < 3; c++) begin
            checks++; if (ready_o !== 1'b0) $display("FAIL stall_ready got=%0h exp=0", ready_o); else passed++;
            @(posedge clk_i); #1;
            checks++; if (result_o !== hold_r) $display("FAIL stall_result got=%0h exp=%0h", result_o, hold_r); else passed++;
            checks++; if (tag_o !== hold_t) $display("FAIL stall_tag got=%0h exp=%0h", tag_o, hold_t); else passed++;
        end
        ready_i = 1'b1;
        repeat (10) begin @(posedge clk_i); #1; end
        checks++; if (got_q.size() !== 8 || exp_q.size() !== 8)
            $display("FAIL stream_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [35:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) $display("FAIL stream_sb got=%0h exp=%0h", g, e); else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_async_reset;
        int seen;
        logic [35:0] e, g;
        set_op(16'd5, 16'd5, 1'b0, 1'b0, 4'd1);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (6) begin @(posedge clk_i); #1; end
        set_op(16'd100, 16'd200, 1'b0, 1'b0, 4'd2);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        set_op(16'd300, 16'd400, 1'b0, 1'b0, 4'd3);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checks++; if (result_o !== 32'd25) $display("FAIL pre_reset_result got=%0h exp=19", result_o); else passed++;
        #3;
        rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) $display("FAIL async_valid got=%0h exp=0", valid_o); else passed++;
        checks++; if (result_o !== 32'h0) $display("FAIL async_result got=%0h exp=0", result_o); else passed++;
        checks++; if (ready_o !== 1'b0) $display("FAIL async_ready got=%0h exp=0", ready_o); else passed++;
        checks++; if (got_q.size() !== 1) $display("FAIL pre_reset_count got=%0d exp=1", got_q.size()); else passed++;
        if (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) $display("FAIL pre_reset_sb got=%0h exp=%0h", g, e); else passed++;
        end
        exp_q.delete(); got_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL post_reset_valid got=%0d exp=0", seen); else passed++;
        checks++; if (got_q.size() !== 0) $display("FAIL post_reset_results got=%0d exp=0", got_q.size()); else passed++;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_flush;
        int seen, lat;
        for (int i = 0; i < 3; i++) begin
            set_op(16'(1000 + i), 16'(77 + i), 1'b0, 1'b0, 4'(i + 1));
            valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        set_op(16'd2, 16'd2, 1'b0, 1'b0, 4'd9);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (valid_o) seen++;
            @(posedge clk_i); #1;
        end
        checks++; if (seen !== 0) $display("FAIL flush_valid got=%0d exp=0", seen); else passed++;
        checks++; if (got_q.size() !== 0) $display("FAIL flush_results got=%0d exp=0", got_q.size()); else passed++;
        exp_q.delete(); got_q.delete();
        set_op(16'd7, 16'd9, 1'b0, 1'b0, 4'd5);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
        checks++; if (lat !== 4) $display("FAIL flush_next_latency got=%0d exp=4", lat); else passed++;
        checks++; if (result_o !== 32'd63) $display("FAIL flush_next_result got=%0h exp=3f", result_o); else passed++;
        repeat (2) begin @(posedge clk_i); #1; end
        checks++; if (got_q.size() !== 1) $display("FAIL flush_next_count got=%0d exp=1", got_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [35:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) $display("FAIL flush_next_sb got=%0h exp=%0h", g, e); else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_freeze;
        int lat;
        set_op(16'd1234, 16'hFFFB, 1'b0, 1'b1, 4'd6);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 0;
        @(posedge clk_i); #1; lat++;
        clk_en_i = 1'b0;
        flush_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (ready_o !== 1'b0) $display("FAIL freeze_ready got=%0h exp=0", ready_o); else passed++;
            @(posedge clk_i); #1; lat++;
            flush_i = 1'b0;
        end
        clk_en_i = 1'b1;
        while (!valid_o && lat < 30) begin @(posedge clk_i); #1; lat++; end
        checks++; if (lat !== 9) $display("FAIL freeze_latency got=%0d exp=9", lat); else passed++;
        checks++; if (result_o !== 32'hFFFFE7E6) $display("FAIL freeze_result got=%0h exp=ffffe7e6", result_o); else passed++;
        repeat (2) begin @(posedge clk_i); #1; end
        checks++; if (got_q.size() !== 1) $display("FAIL freeze_count got=%0d exp=1", got_q.size()); else passed++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [35:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) $display("FAIL freeze_sb got=%0h exp=%0h", g, e); else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rst_i = 1'b1; clk_en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        set_op(16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
        test_reset;
        test_unsigned;
        test_signed;
        test_streaming;
        test_async_reset;
        test_flush;
        test_freeze;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
